// File: rtl/mips32_mem_arbiter_if.sv
// Bus bundle between the pipeline ports, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mips32_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              hlt;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  hlt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output hlt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Arbitrates the unified MIPS32 memory between fetch and data ports; data wins
// unless it has starved a pending fetch for STREAK_MAX consecutive grants.
//   state | meaning
//   IDLE  | grants allowed; writes complete here in a single cycle
//   WAIT  | read in flight, counting down memory latency
//   RESP  | owner's rvalid pulse, no grants
module mips32_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STREAK_MAX = 4
) (
  input logic                 clk1,
  input logic                 rst,
  mips32_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  state_t            state;
  owner_t            owner;
  logic [2:0]        cnt;
  logic [3:0]        streak;
  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              fetch_ok, grant_d, grant_f;

  assign fetch_ok = bus.if_req & ~bus.hlt;
  // Grants are combinational from IDLE only; forced low while reset is asserted.
  assign grant_d  = ~rst && (state == IDLE) && bus.d_req &&
                    !(fetch_ok && (streak == 4'(STREAK_MAX)));
  assign grant_f  = ~rst && (state == IDLE) && fetch_ok && !grant_d;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_NONE;
      cnt         <= '0;
      streak      <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;

      if (!fetch_ok || grant_f)
        streak <= '0;
      else if (grant_d && streak != 4'(STREAK_MAX))
        streak <= streak + 4'd1;

      case (state)
        IDLE: begin
          if (grant_d && !bus.d_we) begin
            owner <= OWN_D;
            cnt   <= 3'(MEM_LAT);
            state <= WAIT;
          end else if (grant_f) begin
            owner <= OWN_IF;
            cnt   <= 3'(MEM_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd1) begin
            if (owner == OWN_D) begin
              d_rdata_q  <= bus.mem_rdata;
              d_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= bus.mem_rdata;
              if_rvalid_q <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = grant_f;
  assign bus.d_gnt     = grant_d;
  assign bus.mem_en    = grant_f | grant_d;
  assign bus.mem_we    = grant_d & bus.d_we;
  assign bus.mem_addr  = grant_d ? bus.d_addr : bus.if_addr;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter: a cycle table for grant/handshake
// behaviour plus hand sequences for read latency, streak order, hlt and reset abort.
module tb_mips32_mem_arbiter;
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  mips32_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STREAK_MAX(4)) dut (
    .clk1(clk1),
    .rst (rst),
    .bus (bus)
  );

  // single-cycle synchronous memory: read data valid the cycle after the grant edge
  logic [31:0] mem [1024];
  logic [31:0] rd_q;
  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            rd_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rd_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk1);
    #1;
  endtask

  // exp = {if_gnt, d_gnt, mem_we, busy, if_rvalid, d_rvalid}
  typedef struct {
    logic       r;
    logic       h;
    logic       ifr;
    logic       dr;
    logic       dwe;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int    ngr, drv, irv, gcnt;
    bit    got;
    string order;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'b000000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b011000};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b011000};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b011000};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b011000};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b011000};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b011000};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b011000};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b011000};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b100000};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b000100};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b000110};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b011000};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};

    bus.hlt = 0; bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 10'd121; bus.d_wdata = 32'd130;
    rst = 1;
    next_cyc();
    @(negedge clk1);
    chk("reset_if_rdata", 64'(bus.if_rdata), 64'h0);
    chk("reset_d_rdata",  64'(bus.d_rdata),  64'h0);
    next_cyc();

    // cycle table
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].r; bus.hlt = tbl[i].h; bus.if_req = tbl[i].ifr;
      bus.d_req = tbl[i].dr; bus.d_we = tbl[i].dwe;
      @(negedge clk1);
      chk($sformatf("tbl_row%0d", i),
          64'({bus.if_gnt, bus.d_gnt, bus.mem_we, bus.busy, bus.if_rvalid, bus.d_rvalid}),
          64'(tbl[i].exp));
      next_cyc();
    end

    // preload memory through the data write path
    for (int k = 0; k < 3; k++) begin
      bus.d_req = 1; bus.d_we = 1;
      bus.d_addr  = (k == 0) ? 10'd0 : (k == 1) ? 10'd120 : 10'd5;
      bus.d_wdata = (k == 0) ? 32'h28010078 : (k == 1) ? 32'd85 : 32'hCAFE0005;
      @(negedge clk1);
      chk("preload_gnt", 64'({bus.d_gnt, bus.mem_we}), 64'b11);
      next_cyc();
    end
    bus.d_req = 0; bus.d_we = 0;
    next_cyc();

    // fetch read latency with MEM_LAT=1
    bus.if_req = 1; bus.if_addr = 10'd0;
    @(negedge clk1); chk("fetch_gnt_T", 64'(bus.if_gnt), 64'h1);
    next_cyc(); bus.if_req = 0;
    @(negedge clk1); chk("fetch_T1_busy_rv", 64'({bus.busy, bus.if_rvalid}), 64'b10);
    next_cyc();
    @(negedge clk1);
    chk("fetch_T2_rvalid", 64'(bus.if_rvalid), 64'h1);
    chk("fetch_T2_rdata", 64'(bus.if_rdata), 64'h28010078);
    next_cyc(); bus.if_req = 1;
    @(negedge clk1); chk("fetch_T3_regrant", 64'(bus.if_gnt), 64'h1);
    next_cyc(); bus.if_req = 0;
    repeat (4) next_cyc();

    // streak order with both ports reading
    bus.if_req = 1; bus.if_addr = 10'd0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd120;
    order = ""; ngr = 0; drv = 0; irv = 0;
    for (int c = 0; c < 60 && ngr < 6; c++) begin
      @(negedge clk1);
      if (bus.if_gnt) begin order = {order, "F"}; ngr++; end
      if (bus.d_gnt)  begin order = {order, "D"}; ngr++; end
      if (bus.d_rvalid) begin drv++; chk("streak_d_rdata", 64'(bus.d_rdata), 64'd85); end
      if (bus.if_rvalid) begin irv++; chk("streak_if_rdata", 64'(bus.if_rdata), 64'h28010078); end
      next_cyc();
    end
    bus.if_req = 0; bus.d_req = 0;
    if (ngr < 6) chk("streak_timeout", 64'(ngr), 64'd6);
    total++;
    if (order != "DDDDFD") begin
      bad++;
      $display("FAIL streak_order: got %s expected DDDDFD", order);
    end
    chk("streak_d_rvalids",  64'(drv), 64'd4);
    chk("streak_if_rvalids", 64'(irv), 64'd1);
    repeat (4) next_cyc();

    // hlt blocks new fetches but lets an outstanding one finish
    bus.hlt = 1; bus.if_req = 1; bus.if_addr = 10'd5; gcnt = 0;
    repeat (6) begin
      @(negedge clk1); if (bus.if_gnt) gcnt++;
      next_cyc();
    end
    chk("hlt_no_gnt", 64'(gcnt), 64'd0);
    bus.hlt = 0;
    @(negedge clk1); chk("hlt_release_gnt", 64'(bus.if_gnt), 64'h1);
    next_cyc(); bus.hlt = 1;
    got = 0; gcnt = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk1);
      if (bus.if_gnt) gcnt++;
      if (bus.if_rvalid) begin
        got = 1;
        chk("hlt_inflight_rdata", 64'(bus.if_rdata), 64'hCAFE0005);
      end
      next_cyc();
    end
    chk("hlt_inflight_rvalid", 64'(got), 64'h1);
    repeat (3) begin
      @(negedge clk1); if (bus.if_gnt) gcnt++;
      next_cyc();
    end
    chk("hlt_gnt_after", 64'(gcnt), 64'd0);
    bus.hlt = 0; bus.if_req = 0;
    next_cyc();

    // reset during WAIT abandons the load
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd120;
    @(negedge clk1); chk("abort_gnt", 64'(bus.d_gnt), 64'h1);
    next_cyc(); bus.d_req = 0; rst = 1;
    next_cyc(); rst = 0;
    @(negedge clk1);
    chk("abort_busy_rvalid", 64'({bus.busy, bus.d_rvalid}), 64'b00);
    chk("abort_rdata_cleared", 64'(bus.d_rdata), 64'h0);
    next_cyc();
    @(negedge clk1); chk("abort_no_rvalid", 64'({bus.busy, bus.d_rvalid}), 64'b00);
    next_cyc();
    bus.d_req = 1;
    @(negedge clk1); chk("fresh_gnt", 64'(bus.d_gnt), 64'h1);
    next_cyc(); bus.d_req = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk1);
      if (bus.d_rvalid) begin
        got = 1;
        chk("fresh_rdata", 64'(bus.d_rdata), 64'd85);
      end
      next_cyc();
    end
    chk("fresh_rvalid", 64'(got), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
